// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Brings the system out of reset once the PLL clock is trustworthy.
//   The asynchronous PLL lock flag is double-flopped into this clock domain.
//   After lock has been stable long enough, the sequencer releases the
//   peripheral reset first, then the core reset a fixed number of cycles later.
//   Losing lock after the peripherals are released re-asserts both resets and
//   bumps a saturating event counter. A soft reset from RUN re-runs only the
//   core reset window.
//   CNT_W must satisfy 2**CNT_W > max(LOCK_STABLE, CORE_DELAY). Under that
//   constraint the terminal compare is always reached before cnt could wrap.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE = 1024,
  parameter int CORE_DELAY  = 16,
  parameter int CNT_W       = 16
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       periph_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_PERIPH    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY - 1);

  // Two-stage lock synchroniser; locked_s is the stage-two output.
  logic [1:0]       sync_q;
  logic             locked_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             periph_rst_q, periph_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             ready_q, ready_d;
  logic [7:0]       loss_cnt_q, loss_cnt_d;
  logic             lock_loss_s;

  assign locked_s = sync_q[1];

  // Lock is only a "loss" once the peripherals have been released.
  assign lock_loss_s = !locked_s && ((state_q == S_PERIPH) || (state_q == S_RUN));

  // Double-flop the asynchronous PLL lock into the clock domain.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  // State and shared delay counter registers.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= S_WAIT_LOCK;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; lock loss outranks soft_reset, which outranks the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          // Lock glitch before release simply restarts the stability wait.
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_PERIPH;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_STABLE;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_PERIPH: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CORE_LAST) begin
          state_d = S_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_PERIPH;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (soft_reset) begin
          // Re-run only the core reset window; peripherals stay released.
          state_d = S_PERIPH;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_RUN;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so outputs move with the transition.
  always_comb begin
    periph_rst_d = 1'b1;
    core_rst_d   = 1'b1;
    ready_d      = 1'b0;
    case (state_d)
      S_WAIT_LOCK, S_STABLE: begin
        periph_rst_d = 1'b1;
        core_rst_d   = 1'b1;
        ready_d      = 1'b0;
      end
      S_PERIPH: begin
        periph_rst_d = 1'b0;
        core_rst_d   = 1'b1;
        ready_d      = 1'b0;
      end
      S_RUN: begin
        periph_rst_d = 1'b0;
        core_rst_d   = 1'b0;
        ready_d      = 1'b1;
      end
      default: begin
        periph_rst_d = 1'b1;
        core_rst_d   = 1'b1;
        ready_d      = 1'b0;
      end
    endcase
    if (lock_loss_s && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end else begin
      loss_cnt_d = loss_cnt_q;
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      periph_rst_q <= 1'b1;
      core_rst_q   <= 1'b1;
      ready_q      <= 1'b0;
      loss_cnt_q   <= 8'd0;
    end else begin
      periph_rst_q <= periph_rst_d;
      core_rst_q   <= core_rst_d;
      ready_q      <= ready_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign periph_rst      = periph_rst_q;
  assign core_rst        = core_rst_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_cnt_q;
  assign state           = {1'b0, state_q};

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with LOCK_STABLE=16, CORE_DELAY=8.
// Expected output vectors {periph_rst, core_rst, ready, lock_loss_count, state}
// are pushed into a scoreboard queue as stimulus is driven and popped after
// the corresponding clock edge.
module tb_pll_reset_sequencer;

  localparam int LS = 16;
  localparam int CD = 8;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_reset;
  logic       periph_rst;
  logic       core_rst;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  logic [13:0] obs;
  logic [13:0] exp_v;
  logic [13:0] sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  assign obs = {periph_rst, core_rst, ready, lock_loss_count, state};

  pll_reset_sequencer #(.LOCK_STABLE(LS), .CORE_DELAY(CD), .CNT_W(16)) dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .soft_reset      (soft_reset),
    .periph_rst      (periph_rst),
    .core_rst        (core_rst),
    .ready           (ready),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  always #5 clock = ~clock;

  // Expected outputs n edges after the first pll_locked=1 sample (edge 0).
  function automatic logic [13:0] seq_exp(input int n, input logic [7:0] cnt);
    logic p, c, r;
    logic [2:0] st;
    if (n < 2)                st = 3'd0;
    else if (n < LS + 2)      st = 3'd1;
    else if (n < LS + 2 + CD) st = 3'd2;
    else                      st = 3'd3;
    p = (n < LS + 2);
    c = (n < LS + 2 + CD);
    r = !c;
    return {p, c, r, cnt, st};
  endfunction

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b1; soft_reset = 1'b0;
    repeat (3) edge1();
    sb.push_back({1'b1, 1'b1, 1'b0, 8'd0, 3'd0});
    exp_v = sb.pop_front();
    n_checks++;
    if (obs !== exp_v) $display("FAIL reset_state: got %b want %b", obs, exp_v);
    else n_pass++;
    rst_n = 1'b1;
    for (int n = 0; n <= LS + CD + 3; n++) begin
      sb.push_back(seq_exp(n, 8'd0));
      edge1();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL startup edge %0d: got %b want %b", n, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_stable_glitch();
    rst_n = 1'b0; pll_locked = 1'b1; soft_reset = 1'b0;
    repeat (2) edge1();
    rst_n = 1'b1;
    for (int n = 0; n <= 11 + LS + CD + 2; n++) begin
      pll_locked = (n != 10);
      sb.push_back((n < 12) ? seq_exp(n, 8'd0) : seq_exp(n - 11, 8'd0));
      edge1();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL stable_glitch edge %0d: got %b want %b", n, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_run_loss();
    for (int n = 0; n <= 1 + LS + CD + 2; n++) begin
      pll_locked = (n != 0);
      sb.push_back((n < 2) ? seq_exp(100, 8'd0) : seq_exp(n - 1, 8'd1));
      edge1();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL run_loss edge %0d: got %b want %b", n, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_soft_reset();
    for (int n = 0; n <= CD + 1; n++) begin
      soft_reset = (n == 0);
      sb.push_back((n < CD) ? {1'b0, 1'b1, 1'b0, 8'd1, 3'd2} : {1'b0, 1'b0, 1'b1, 8'd1, 3'd3});
      edge1();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL soft_run edge %0d: got %b want %b", n, obs, exp_v);
      else n_pass++;
    end
    // Outside RUN (STABLE at m=8, PERIPH at m=22) soft_reset must be ignored.
    for (int m = 0; m <= 1 + LS + CD + 2; m++) begin
      pll_locked = (m != 0);
      soft_reset = (m == 8) || (m == 22);
      sb.push_back((m < 2) ? seq_exp(100, 8'd1) : seq_exp(m - 1, 8'd2));
      edge1();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL soft_ignored edge %0d: got %b want %b", m, obs, exp_v);
      else n_pass++;
    end
    soft_reset = 1'b0;
  endtask

  task automatic test_loss_priority_saturate();
    int   exp_cnt;
    bit   found;
    for (int m = 0; m <= 2; m++) begin
      pll_locked = (m != 0);
      soft_reset = (m == 2);
      sb.push_back((m < 2) ? seq_exp(100, 8'd2) : seq_exp(1, 8'd3));
      edge1();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL loss_vs_soft edge %0d: got %b want %b", m, obs, exp_v);
      else n_pass++;
    end
    soft_reset = 1'b0;
    exp_cnt = 3;
    for (int i = 0; i < 300; i++) begin
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
        if (state == 3'd2) found = 1'b1;
        else edge1();
      end
      if (!found) begin
        n_checks++;
        $display("FAIL saturate_wait loss %0d: PERIPH not reached, state=%0d", i, state);
        break;
      end
      pll_locked = 1'b0;
      edge1();
      pll_locked = 1'b1;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      sb.push_back({1'b1, 1'b1, 1'b0, 8'(exp_cnt), 3'd0});
      edge1();
      edge1();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL saturate loss %0d: got %b want %b", i, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_periph();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (state == 3'd2) found = 1'b1;
      else edge1();
    end
    if (!found) begin
      n_checks++;
      $display("FAIL reset_mid_wait: PERIPH not reached, state=%0d", state);
    end else begin
      rst_n = 1'b0;
      sb.push_back({1'b1, 1'b1, 1'b0, 8'd0, 3'd0});
      edge1();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL reset_mid: got %b want %b", obs, exp_v);
      else n_pass++;
      rst_n = 1'b1;
      sb.push_back({1'b1, 1'b1, 1'b0, 8'd0, 3'd0});
      edge1();
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL reset_mid_release: got %b want %b", obs, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stable_glitch();
    test_run_loss();
    test_soft_reset();
    test_loss_priority_saturate();
    test_reset_mid_periph();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
